// File: rtl/lsu_bus_master.sv
// Load/store bus master: turns byte/half/word requests into word bus cycles, RMW for sub-word stores.
// Optional performance counters enabled by defining LSU_PERF_CNT_EN.
module lsu_bus_master #(
    parameter logic [31:0] MMIO_BASE = 32'h40000000,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_sign,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 ram_enable,
    output logic                 is_write_o,
    output logic [31:0]          address_o,
    output logic [31:0]          wdata_o,
    input  logic [31:0]          rdata_i,
    output logic [CNT_WIDTH-1:0] ld_cnt,
    output logic [CNT_WIDTH-1:0] st_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_MRG,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_word;

    logic        w_accept;
    logic        w_misal;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // Error priority only matters for documentation; any hit yields the same error response.
    assign w_misal = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_err   = (req_size == 2'b11) || w_misal ||
                     ((req_size != 2'b10) && (req_addr >= MMIO_BASE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_write <= 1'b0;
            r_size  <= 2'b00;
            r_sign  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_word  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= req_write;
                r_size  <= req_size;
                r_sign  <= req_sign;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= w_err;
            end
            if (r_state == S_RD) begin
                r_word <= rdata_i;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err)
                        w_next = S_RESP;
                    else if (req_write && (req_size == 2'b10))
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end
            end
            S_RD:    w_next = r_write ? S_MRG : S_RESP;
            S_WR:    w_next = S_RESP;
            S_MRG:   w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Little-endian lane select: byte lane addr[1:0], half lane addr[1].
    assign w_byte = r_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_word[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load = r_word;
        case (r_size)
            2'b00:   w_load = {{24{r_sign & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sign & w_half[15]}}, w_half};
            default: w_load = r_word;
        endcase
    end

    always_comb begin
        w_merged = r_word;
        if (r_size == 2'b00)
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        ram_enable = 1'b0;
        is_write_o = 1'b0;
        address_o  = '0;
        wdata_o    = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_RD: begin
                ram_enable = 1'b1;
                address_o  = {r_addr[31:2], 2'b00};
            end
            S_WR: begin
                is_write_o = 1'b1;
                address_o  = {r_addr[31:2], 2'b00};
                wdata_o    = r_wdata;
            end
            S_MRG: begin
                is_write_o = 1'b1;
                address_o  = {r_addr[31:2], 2'b00};
                wdata_o    = w_merged;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                if (!r_err && !r_write)
                    resp_rdata = w_load;
            end
            default: ;
        endcase
    end

`ifdef LSU_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_ld_cnt;
    logic [CNT_WIDTH-1:0] r_st_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_cnt <= '0;
            r_st_cnt <= '0;
        end else if ((r_state == S_RESP) && !r_err) begin
            if (r_write)
                r_st_cnt <= r_st_cnt + 1'b1;
            else
                r_ld_cnt <= r_ld_cnt + 1'b1;
        end
    end

    assign ld_cnt = r_ld_cnt;
    assign st_cnt = r_st_cnt;
`else
    assign ld_cnt = '0;
    assign st_cnt = '0;
`endif

endmodule
